// File: rtl/axi_llc_hit_miss_unit.sv
// LLC hit/miss classifier: 4-way tag store with per-set tree PLRU, one-cycle lookup
// into a single output register that is steered to either the hit or the miss path.
module axi_llc_hit_miss_unit #(
    parameter int unsigned SetAssoc     = 4,
    parameter int unsigned IndexLength  = 6,
    parameter int unsigned OffsetLength = 4,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned TagLength    = AddrWidth - IndexLength - OffsetLength
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 test_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [AddrWidth-1:0] desc_addr_i,
    input  logic                 desc_rw_i,
    input  logic                 desc_flush_i,
    input  logic [SetAssoc-1:0]  desc_way_ind_i,
    input  logic [SetAssoc-1:0]  spm_lock_i,
    input  logic [SetAssoc-1:0]  flushed_i,
    output logic                 hit_valid_o,
    input  logic                 hit_ready_i,
    output logic                 miss_valid_o,
    input  logic                 miss_ready_i,
    output logic [AddrWidth-1:0] desc_addr_o,
    output logic                 desc_rw_o,
    output logic                 desc_flush_o,
    output logic [SetAssoc-1:0]  desc_way_o,
    output logic                 desc_evict_o,
    output logic [TagLength-1:0] desc_evict_tag_o,
    output logic                 desc_refill_o,
    output logic [SetAssoc-1:0]  bist_res_o,
    output logic                 bist_valid_o
);
    localparam int unsigned NumSets = 1 << IndexLength;

    function automatic logic [SetAssoc-1:0] lowest_one(input logic [SetAssoc-1:0] vec);
        return vec & (~vec + SetAssoc'(1));
    endfunction

    // Tree bits: [0] root (1 = victim in ways 2/3), [1] pair 0/1, [2] pair 2/3.
    function automatic logic [SetAssoc-1:0] plru_victim(input logic [2:0] bits);
        logic [SetAssoc-1:0] oh;
        if (bits[0]) begin
            oh = bits[2] ? 4'b1000 : 4'b0100;
        end else begin
            oh = bits[1] ? 4'b0010 : 4'b0001;
        end
        return oh;
    endfunction

    function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [SetAssoc-1:0] oh);
        logic [2:0] nxt;
        nxt = bits;
        if (oh[0]) begin
            nxt[0] = 1'b1;
            nxt[1] = 1'b1;
        end else if (oh[1]) begin
            nxt[0] = 1'b1;
            nxt[1] = 1'b0;
        end else if (oh[2]) begin
            nxt[0] = 1'b0;
            nxt[2] = 1'b1;
        end else if (oh[3]) begin
            nxt[0] = 1'b0;
            nxt[2] = 1'b0;
        end
        return nxt;
    endfunction

    logic [SetAssoc-1:0]  r_valid [NumSets];
    logic [SetAssoc-1:0]  r_dirty [NumSets];
    logic [TagLength-1:0] r_tag   [NumSets][SetAssoc];
    logic [2:0]           r_plru  [NumSets];

    logic                   r_init_busy;
    logic                   r_init_done;
    logic                   r_bist_valid;
    logic [IndexLength-1:0] r_init_cnt;

    logic                 r_out_valid;
    logic                 r_out_hit;
    logic [AddrWidth-1:0] r_addr;
    logic                 r_rw;
    logic                 r_flush;
    logic [SetAssoc-1:0]  r_way;
    logic                 r_evict;
    logic [TagLength-1:0] r_evict_tag;
    logic                 r_refill;

    logic [IndexLength-1:0] w_index;
    logic [TagLength-1:0]   w_tag;
    logic [SetAssoc-1:0]    w_set_valid;
    logic [SetAssoc-1:0]    w_set_dirty;
    logic [SetAssoc-1:0]    w_elig;
    logic [SetAssoc-1:0]    w_match;
    logic [SetAssoc-1:0]    w_hit_oh;
    logic [SetAssoc-1:0]    w_free;
    logic [SetAssoc-1:0]    w_plru_oh;
    logic [SetAssoc-1:0]    w_victim_oh;
    logic [TagLength-1:0]   w_victim_tag;
    logic [TagLength-1:0]   w_flush_tag;
    logic [SetAssoc-1:0]    w_clear_mask;
    logic                   w_hit;
    logic                   w_victim_dirty;
    logic                   w_flush_dirty;
    logic                   w_out_accepted;
    logic                   w_accept;
    logic                   w_unused;

    assign w_unused    = test_i;
    assign w_index     = desc_addr_i[OffsetLength +: IndexLength];
    assign w_tag       = desc_addr_i[AddrWidth-1 -: TagLength];
    assign w_set_valid = r_valid[w_index];
    assign w_set_dirty = r_dirty[w_index];
    assign w_elig      = ~(spm_lock_i | flushed_i);

    genvar gi;
    generate
        for (gi = 0; gi < SetAssoc; gi++) begin : g_way
            assign w_match[gi] = w_elig[gi] & w_set_valid[gi] & (r_tag[w_index][gi] == w_tag);
        end
    endgenerate

    assign w_hit     = |w_match;
    assign w_hit_oh  = lowest_one(w_match);
    assign w_free    = w_elig & ~w_set_valid;
    assign w_plru_oh = plru_victim(r_plru[w_index]);

    // Prefer empty ways, then the PLRU choice, then anything still eligible (may be none).
    always_comb begin
        if (|w_free) begin
            w_victim_oh = lowest_one(w_free);
        end else if (|(w_plru_oh & w_elig)) begin
            w_victim_oh = w_plru_oh;
        end else begin
            w_victim_oh = lowest_one(w_elig);
        end
    end

    always_comb begin
        w_victim_tag = '0;
        w_flush_tag  = '0;
        for (int w = 0; w < SetAssoc; w++) begin
            if (w_victim_oh[w] & w_set_valid[w]) begin
                w_victim_tag = w_victim_tag | r_tag[w_index][w];
            end
            if (desc_way_ind_i[w] & w_set_valid[w]) begin
                w_flush_tag = w_flush_tag | r_tag[w_index][w];
            end
        end
    end

    assign w_victim_dirty = |(w_victim_oh & w_set_valid & w_set_dirty);
    assign w_flush_dirty  = |(desc_way_ind_i & w_set_valid & w_set_dirty);

    // Per-way self check: every set must read back with valid and dirty cleared.
    always_comb begin
        w_clear_mask = '1;
        for (int s = 0; s < NumSets; s++) begin
            w_clear_mask = w_clear_mask & ~(r_valid[s] | r_dirty[s]);
        end
    end

    assign hit_valid_o    = r_out_valid & r_out_hit;
    assign miss_valid_o   = r_out_valid & ~r_out_hit;
    assign w_out_accepted = r_out_hit ? (r_out_valid & hit_ready_i) : (r_out_valid & miss_ready_i);
    assign ready_o        = r_init_done & (~r_out_valid | w_out_accepted);
    assign w_accept       = valid_i & ready_o;

    assign bist_valid_o = r_bist_valid;
    assign bist_res_o   = r_bist_valid ? w_clear_mask : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_init_busy  <= 1'b1;
            r_init_done  <= 1'b0;
            r_bist_valid <= 1'b0;
            r_init_cnt   <= '0;
        end else begin
            r_bist_valid <= 1'b0;
            if (r_init_busy) begin
                r_init_cnt <= r_init_cnt + IndexLength'(1);
                if (r_init_cnt == IndexLength'(NumSets - 1)) begin
                    r_init_busy  <= 1'b0;
                    r_bist_valid <= 1'b1;
                end
            end
            if (r_bist_valid) begin
                r_init_done <= 1'b1;
            end
        end
    end

    // Tag store is not reset directly; the sweep clears it before any request is accepted.
    always_ff @(posedge clk_i) begin
        if (r_init_busy) begin
            r_valid[r_init_cnt] <= '0;
            r_dirty[r_init_cnt] <= '0;
            r_plru[r_init_cnt]  <= '0;
        end else if (w_accept) begin
            if (desc_flush_i) begin
                r_valid[w_index] <= w_set_valid & ~desc_way_ind_i;
                r_dirty[w_index] <= w_set_dirty & ~desc_way_ind_i;
            end else if (w_hit) begin
                if (desc_rw_i) begin
                    r_dirty[w_index] <= w_set_dirty | w_hit_oh;
                end
                r_plru[w_index] <= plru_touch(r_plru[w_index], w_hit_oh);
            end else if (|w_victim_oh) begin
                r_valid[w_index] <= w_set_valid | w_victim_oh;
                r_dirty[w_index] <= desc_rw_i ? (w_set_dirty | w_victim_oh)
                                              : (w_set_dirty & ~w_victim_oh);
                for (int w = 0; w < SetAssoc; w++) begin
                    if (w_victim_oh[w]) begin
                        r_tag[w_index][w] <= w_tag;
                    end
                end
                r_plru[w_index] <= plru_touch(r_plru[w_index], w_victim_oh);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_out_hit   <= 1'b0;
            r_addr      <= '0;
            r_rw        <= 1'b0;
            r_flush     <= 1'b0;
            r_way       <= '0;
            r_evict     <= 1'b0;
            r_evict_tag <= '0;
            r_refill    <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_hit   <= ~desc_flush_i & w_hit;
            r_addr      <= desc_addr_i;
            r_rw        <= desc_rw_i;
            r_flush     <= desc_flush_i;
            if (desc_flush_i) begin
                r_way       <= desc_way_ind_i;
                r_evict     <= w_flush_dirty;
                r_evict_tag <= w_flush_tag;
                r_refill    <= 1'b0;
            end else if (w_hit) begin
                r_way       <= w_hit_oh;
                r_evict     <= 1'b0;
                r_evict_tag <= '0;
                r_refill    <= 1'b0;
            end else begin
                r_way       <= w_victim_oh;
                r_evict     <= w_victim_dirty;
                r_evict_tag <= w_victim_tag;
                r_refill    <= |w_victim_oh;
            end
        end else if (w_out_accepted) begin
            r_out_valid <= 1'b0;
        end
    end

    assign desc_addr_o      = r_addr;
    assign desc_rw_o        = r_rw;
    assign desc_flush_o     = r_flush;
    assign desc_way_o       = r_way;
    assign desc_evict_o     = r_evict;
    assign desc_evict_tag_o = r_evict_tag;
    assign desc_refill_o    = r_refill;

endmodule

// File: tb/tb_axi_llc_hit_miss_unit.sv
// Randomized bench for axi_llc_hit_miss_unit against a recency-timestamp cache model.
module tb_axi_llc_hit_miss_unit;
    localparam int AW = 32, IL = 6, OL = 4, TL = 22, WAYS = 4, SETS = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          test_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [AW-1:0] desc_addr_i = '0;
    logic          desc_rw_i = 1'b0;
    logic          desc_flush_i = 1'b0;
    logic [3:0]    desc_way_ind_i = '0;
    logic [3:0]    spm_lock_i = '0;
    logic [3:0]    flushed_i = '0;
    logic          hit_valid_o, miss_valid_o;
    logic          hit_ready_i = 1'b1;
    logic          miss_ready_i = 1'b1;
    logic [AW-1:0] desc_addr_o;
    logic          desc_rw_o, desc_flush_o, desc_evict_o, desc_refill_o, bist_valid_o;
    logic [3:0]    desc_way_o, bist_res_o;
    logic [TL-1:0] desc_evict_tag_o;

    always #5 clk = ~clk;

    axi_llc_hit_miss_unit dut (
        .clk_i(clk), .rst_ni(rst_n), .test_i(test_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .desc_addr_i(desc_addr_i), .desc_rw_i(desc_rw_i), .desc_flush_i(desc_flush_i),
        .desc_way_ind_i(desc_way_ind_i), .spm_lock_i(spm_lock_i), .flushed_i(flushed_i),
        .hit_valid_o(hit_valid_o), .hit_ready_i(hit_ready_i),
        .miss_valid_o(miss_valid_o), .miss_ready_i(miss_ready_i),
        .desc_addr_o(desc_addr_o), .desc_rw_o(desc_rw_o), .desc_flush_o(desc_flush_o),
        .desc_way_o(desc_way_o), .desc_evict_o(desc_evict_o),
        .desc_evict_tag_o(desc_evict_tag_o), .desc_refill_o(desc_refill_o),
        .bist_res_o(bist_res_o), .bist_valid_o(bist_valid_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: lines plus a last-touch timestamp per way for the replacement choice.
    bit          mvalid [SETS][WAYS];
    bit          mdirty [SETS][WAYS];
    logic [TL-1:0] mtag [SETS][WAYS];
    int unsigned mstamp [SETS][WAYS];
    int unsigned mtime = 0;

    logic          e_hit, e_evict, e_refill;
    logic [3:0]    e_way;
    logic [TL-1:0] e_etag;

    task automatic model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                mvalid[s][w] = 0; mdirty[s][w] = 0; mstamp[s][w] = 0;
            end
    endtask

    task automatic touch(input int s, input int w);
        mtime++;
        mstamp[s][w] = mtime;
    endtask

    // Tree PLRU: victim lies in the pair not used most recently, and within
    // that pair is the way not used most recently (untouched ties pick the lower).
    function automatic int plru_pick(input int s);
        int unsigned lmax, rmax;
        int base;
        lmax = (mstamp[s][0] > mstamp[s][1]) ? mstamp[s][0] : mstamp[s][1];
        rmax = (mstamp[s][2] > mstamp[s][3]) ? mstamp[s][2] : mstamp[s][3];
        base = (lmax > rmax) ? 2 : 0;
        return (mstamp[s][base+1] < mstamp[s][base]) ? base + 1 : base;
    endfunction

    task automatic model_req(input logic [AW-1:0] a, input logic rw, input logic fl,
                             input logic [3:0] wi, input logic [3:0] lk, input logic [3:0] fd);
        int s, v, p;
        logic [TL-1:0] t;
        logic [3:0] el;
        s = int'(a[OL +: IL]);
        t = a[AW-1 -: TL];
        el = ~(lk | fd);
        e_hit = 0; e_way = 0; e_evict = 0; e_etag = 0; e_refill = 0; v = -1;
        if (fl) begin
            e_way = wi;
            for (int w = 0; w < WAYS; w++)
                if (wi[w]) begin
                    if (mvalid[s][w] && mdirty[s][w]) begin e_evict = 1; e_etag = mtag[s][w]; end
                    mvalid[s][w] = 0; mdirty[s][w] = 0;
                end
            return;
        end
        for (int w = 0; w < WAYS; w++)
            if (v < 0 && el[w] && mvalid[s][w] && mtag[s][w] == t) v = w;
        if (v >= 0) begin
            e_hit = 1; e_way = 4'(1 << v);
            if (rw) mdirty[s][v] = 1;
            touch(s, v);
            return;
        end
        for (int w = 0; w < WAYS; w++) if (v < 0 && el[w] && !mvalid[s][w]) v = w;
        if (v < 0) begin p = plru_pick(s); if (el[p]) v = p; end
        for (int w = 0; w < WAYS; w++) if (v < 0 && el[w]) v = w;
        if (v < 0) return;
        e_way = 4'(1 << v); e_refill = 1;
        if (mvalid[s][v] && mdirty[s][v]) begin e_evict = 1; e_etag = mtag[s][v]; end
        mvalid[s][v] = 1; mdirty[s][v] = rw; mtag[s][v] = t;
        touch(s, v);
    endtask

    function automatic logic [AW-1:0] mk_addr(input logic [TL-1:0] t, input int s);
        return {t, 6'(s), 4'h0};
    endfunction

    task automatic drive_req(input logic [AW-1:0] a, input logic rw, input logic fl,
                             input logic [3:0] wi, input logic [3:0] lk, input logic [3:0] fd);
        valid_i = 1; desc_addr_i = a; desc_rw_i = rw; desc_flush_i = fl;
        desc_way_ind_i = wi; spm_lock_i = lk; flushed_i = fd;
    endtask

    // Called right after the negedge on which a request was driven.
    task automatic finish_req(input string nm, output int waited);
        waited = 0;
        #1;
        while (!ready_o && waited < 40) begin @(negedge clk); #1; waited++; end
        if (!ready_o) begin
            chk({nm, ":ready_timeout"}, ready_o, 1);
            valid_i = 0;
            return;
        end
        model_req(desc_addr_i, desc_rw_i, desc_flush_i, desc_way_ind_i, spm_lock_i, flushed_i);
        @(posedge clk); #1;
        valid_i = 0;
        @(negedge clk);
        chk({nm, ":hit_valid"}, hit_valid_o, e_hit);
        chk({nm, ":miss_valid"}, miss_valid_o, !e_hit);
        chk({nm, ":way"}, desc_way_o, e_way);
        chk({nm, ":refill"}, desc_refill_o, e_refill);
        chk({nm, ":evict"}, desc_evict_o, e_evict);
        chk({nm, ":addr"}, desc_addr_o, desc_addr_i);
        chk({nm, ":rw_flush"}, {desc_rw_o, desc_flush_o}, {desc_rw_i, desc_flush_i});
        if (e_evict) chk({nm, ":evict_tag"}, desc_evict_tag_o, e_etag);
        $display("req %s addr=%08h rw=%0b fl=%0b lk=%b -> hit=%0b way=%b ev=%0b rf=%0b",
                 nm, desc_addr_i, desc_rw_i, desc_flush_i, spm_lock_i | flushed_i,
                 hit_valid_o, desc_way_o, desc_evict_o, desc_refill_o);
    endtask

    task automatic req(input string nm, input logic [AW-1:0] a, input logic rw, input logic fl,
                       input logic [3:0] wi, input logic [3:0] lk, input logic [3:0] fd);
        int waited;
        @(negedge clk);
        drive_req(a, rw, fl, wi, lk, fd);
        finish_req(nm, waited);
    endtask

    task automatic flush_set(input int s);
        for (int w = 0; w < WAYS; w++) req("flush_set", mk_addr('0, s), 0, 1, 4'(1 << w), 0, 0);
    endtask

    task automatic do_reset_init();
        int cyc;
        bit seen, ready_early;
        rst_n = 0; valid_i = 0;
        repeat (3) @(negedge clk);
        chk("rst:ready", ready_o, 0);
        chk("rst:valids", {hit_valid_o, miss_valid_o, bist_valid_o}, 0);
        chk("rst:fields", {desc_addr_o, desc_way_o, desc_evict_o, desc_refill_o, desc_flush_o}, 0);
        model_clear();
        rst_n = 1;
        cyc = 0; seen = 0; ready_early = 0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bist_valid_o) seen = 1;
            else if (ready_o) ready_early = 1;
        end
        chk("init:cycles", cyc, 64);
        chk("init:bist_res", bist_res_o, 4'hF);
        chk("init:ready_in_pulse", ready_o, 0);
        chk("init:ready_early", ready_early, 0);
        @(negedge clk);
        chk("init:ready_after", ready_o, 1);
        chk("init:pulse_end", bist_valid_o, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] rd_addr [15];
        logic [3:0]    rd_way  [15];
        logic [TL-1:0] t5 [5];
        logic [AW-1:0] a, b, c;
        int waited, k;

        do_reset_init();

        // Cold reads into distinct sets, then re-read four of them.
        for (int i = 0; i < 15; i++) begin
            rd_addr[i] = mk_addr(22'($urandom), i * 4 + int'($urandom_range(0, 3)));
            req("cold_read", rd_addr[i], 0, 0, 0, 0, 0);
            chk("cold_read:is_refill", desc_refill_o, 1);
            rd_way[i] = e_way;
        end
        for (int i = 0; i < 4; i++) begin
            k = int'($urandom_range(0, 14));
            req("reread", rd_addr[k], 0, 0, 0, 0, 0);
            chk("reread:hit", hit_valid_o, 1);
            chk("reread:same_way", desc_way_o, rd_way[k]);
        end

        // Set 5: fill, re-touch ways 3,0,1 so the tree points at dirty way 2.
        flush_set(5);
        for (int i = 0; i < 5; i++) t5[i] = 22'(32'h1000 + i * 32'h111);
        req("s5_fill", mk_addr(t5[0], 5), 0, 0, 0, 0, 0);
        req("s5_fill", mk_addr(t5[1], 5), 0, 0, 0, 0, 0);
        req("s5_fill", mk_addr(t5[2], 5), 1, 0, 0, 0, 0);
        req("s5_fill", mk_addr(t5[3], 5), 0, 0, 0, 0, 0);
        req("s5_touch", mk_addr(t5[3], 5), 0, 0, 0, 0, 0);
        req("s5_touch", mk_addr(t5[0], 5), 0, 0, 0, 0, 0);
        req("s5_touch", mk_addr(t5[1], 5), 0, 0, 0, 0, 0);
        req("s5_new", mk_addr(t5[4], 5), 0, 0, 0, 0, 0);
        chk("s5:victim_way", desc_way_o, 4'b0100);
        chk("s5:evict", desc_evict_o, 1);
        chk("s5:evict_tag", desc_evict_tag_o, t5[2]);

        // Output stall: a hit held for 3 cycles, next request accepted as ready rises.
        hit_ready_i = 0;
        req("stall_hit", mk_addr(t5[4], 5), 0, 0, 0, 0, 0);
        drive_req(mk_addr(t5[0], 5), 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall:hit_valid", hit_valid_o, 1);
            chk("stall:way", desc_way_o, e_way);
            chk("stall:addr", desc_addr_o, mk_addr(t5[4], 5));
            chk("stall:ready", ready_o, 0);
            @(negedge clk);
        end
        hit_ready_i = 1;
        finish_req("stall_next", waited);
        chk("stall:same_cycle_accept", waited, 0);

        // Scratchpad-locked ways 0/1.
        flush_set(9);
        a = mk_addr(22'h2abcd, 9);
        req("spm_pre", a, 0, 0, 0, 0, 0);
        req("spm_lock", a, 0, 0, 0, 4'b0011, 0);
        chk("spm:miss", miss_valid_o, 1);
        chk("spm:way_not_locked", desc_way_o & 4'b0011, 0);
        req("spm_all", mk_addr(22'($urandom), int'($urandom_range(0, 63))), 1, 0, 0, 4'hF, 0);
        chk("spm_all:way", desc_way_o, 0);
        chk("spm_all:refill", desc_refill_o, 0);
        chk("spm_all:miss", miss_valid_o, 1);

        // Flush of a dirty line in way 1.
        flush_set(12);
        b = mk_addr(22'h155aa, 12);
        c = mk_addr(22'h0f0f0, 12);
        req("fl_prep", c, 0, 0, 0, 0, 0);
        req("fl_prep", b, 1, 0, 0, 0, 0);
        req("fl_way1", b, 0, 1, 4'b0010, 0, 0);
        chk("flush:evict", desc_evict_o, 1);
        chk("flush:flag", desc_flush_o, 1);
        chk("flush:tag", desc_evict_tag_o, 22'h155aa);
        req("fl_reread", b, 0, 0, 0, 0, 0);
        chk("flush:reread_miss", miss_valid_o, 1);

        // Random mix over a small tag/set pool to force hits, evictions and flushes.
        for (int i = 0; i < 200; i++) begin
            logic [3:0] lk, fd;
            lk = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
            fd = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            req("rand", mk_addr(22'($urandom_range(1, 6)), int'($urandom_range(0, 3))),
                1'($urandom), ($urandom_range(0, 9) == 0), 4'(1 << $urandom_range(0, 3)), lk, fd);
        end

        // Reset while an output is pending.
        @(negedge clk);
        drive_req(mk_addr(22'h3, 1), 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        valid_i = 0;
        rst_n = 0;
        @(negedge clk);
        chk("midrst:valids", {hit_valid_o, miss_valid_o}, 0);
        chk("midrst:ready", ready_o, 0);
        do_reset_init();
        req("post_reset", rd_addr[0], 0, 0, 0, 0, 0);
        chk("post_reset:miss", miss_valid_o, 1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
